// File: rtl/spi_axi_pkg.sv
// ============================================================================
// Module      : spi_axi_pkg
// Description : Shared encodings and helpers for the QSPI AXI write slave.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package spi_axi_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_DATA = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // Byte mask of the wrap window: (len+1) * 2^size - 1
    function automatic logic [15:0] wrap_mask(input logic [7:0] len, input logic [2:0] size);
        logic [15:0] span;
        span = ({8'd0, len} + 16'd1) << size;
        return span - 16'd1;
    endfunction

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sync_fifo.sv
// ============================================================================
// Module      : spi_sync_fifo
// Description : Single-clock FIFO with registered storage and occupancy count.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == (PW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head entry is zeroed while empty so stale storage never reaches the engine
    assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/spi_axi_wr_slave.sv
// ============================================================================
// Module      : spi_axi_wr_slave
// Description : AXI4 write slave; burst address generation, beat FIFO to SPI engine.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_axi_wr_slave
    import spi_axi_pkg::*;
#(
    parameter int DW         = 128,
    parameter int AW         = 32,
    parameter int IDW        = 6,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [IDW-1:0]    spi_if_awid,
    input  logic [AW-1:0]     spi_if_awaddr,
    input  logic [7:0]        spi_if_awlen,
    input  logic [2:0]        spi_if_awsize,
    input  logic [1:0]        spi_if_awburst,
    input  logic              spi_if_awlock,
    input  logic [2:0]        spi_if_awcache,
    input  logic              spi_if_awvalid,
    output logic              spi_if_awready,
    input  logic [DW-1:0]     spi_if_wdata,
    input  logic [DW/8-1:0]   spi_if_wstrb,
    input  logic              spi_if_wlast,
    input  logic              spi_if_wvalid,
    output logic              spi_if_wready,
    output logic [IDW-1:0]    spi_if_bid,
    output logic [1:0]        spi_if_bresp,
    output logic              spi_if_bvalid,
    input  logic              spi_if_bready,
    output logic              eng_wvalid,
    input  logic              eng_wready,
    output logic [AW-1:0]     eng_waddr,
    output logic [DW-1:0]     eng_wdata,
    output logic [DW/8-1:0]   eng_wstrb,
    output logic              eng_wlast
);

    localparam int         SW       = DW / 8;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(SW));
    localparam int         FW       = AW + DW + SW + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_alive;
    logic [IDW-1:0]   r_id;
    logic [AW-1:0]    r_addr;
    logic [7:0]       r_len;
    logic [2:0]       r_size;
    logic [1:0]       r_burst;
    logic [7:0]       r_beat;
    logic             r_aw_err;
    logic             r_wl_err;

    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_last_beat;
    logic             w_push;
    logic             w_aw_err;
    logic [AW-1:0]    w_size_mask;
    logic [AW-1:0]    w_step;
    logic [AW-1:0]    w_sum;
    logic [AW-1:0]    w_wmask;
    logic [AW-1:0]    w_next_addr;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
    logic [FW-1:0]    w_fifo_in;
    logic [FW-1:0]    w_fifo_out;
    logic             w_unused;

    assign w_unused    = ^{spi_if_awlock, spi_if_awcache, w_fifo_count};

    assign w_aw_hs     = spi_if_awvalid && spi_if_awready;
    assign w_w_hs      = spi_if_wvalid && spi_if_wready;
    assign w_last_beat = (r_beat == r_len);
    assign w_push      = w_w_hs && !r_aw_err;

    assign w_size_mask = (AW'(1) << spi_if_awsize) - AW'(1);
    assign w_aw_err    = (spi_if_awsize > MAX_SIZE)
                      || (spi_if_awburst == 2'b11)
                      || ((spi_if_awburst == BURST_WRAP)
                          && (!wrap_len_ok(spi_if_awlen) || ((spi_if_awaddr & w_size_mask) != '0)));

    // WRAP keeps the bits above the window and wraps the low bits inside it
    assign w_step  = AW'(1) << r_size;
    assign w_sum   = r_addr + w_step;
    assign w_wmask = AW'(wrap_mask(r_len, r_size));

    always_comb begin
        w_next_addr = w_sum;
        case (r_burst)
            BURST_FIXED: w_next_addr = r_addr;
            BURST_WRAP:  w_next_addr = (r_addr & ~w_wmask) | (w_sum & w_wmask);
            default:     w_next_addr = w_sum;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_alive  <= 1'b0;
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_beat   <= '0;
            r_aw_err <= 1'b0;
            r_wl_err <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (w_aw_hs) begin
                r_id     <= spi_if_awid;
                r_addr   <= spi_if_awaddr;
                r_len    <= spi_if_awlen;
                r_size   <= spi_if_awsize;
                r_burst  <= spi_if_awburst;
                r_beat   <= '0;
                r_aw_err <= w_aw_err;
                r_wl_err <= 1'b0;
            end else if (w_w_hs) begin
                r_beat <= r_beat + 8'd1;
                r_addr <= w_next_addr;
                if (spi_if_wlast != w_last_beat) begin
                    r_wl_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_aw_hs)                 w_state_nxt = ST_DATA;
            ST_DATA: if (w_w_hs && w_last_beat)   w_state_nxt = ST_RESP;
            ST_RESP: if (spi_if_bready)           w_state_nxt = ST_IDLE;
            default:                              w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        spi_if_awready = (r_state == ST_IDLE) && r_alive;
        spi_if_wready  = (r_state == ST_DATA) && (r_aw_err || !w_fifo_full);
        spi_if_bvalid  = (r_state == ST_RESP);
    end

    assign spi_if_bid   = r_id;
    assign spi_if_bresp = (r_aw_err || r_wl_err) ? RESP_SLVERR : RESP_OKAY;

    assign w_fifo_in = {r_addr, spi_if_wdata, spi_if_wstrb, w_last_beat};

    spi_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (aclk),
        .rst_n     (aresetn),
        .push      (w_push),
        .push_data (w_fifo_in),
        .pop       (eng_wvalid && eng_wready),
        .pop_data  (w_fifo_out),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    assign eng_wvalid = !w_fifo_empty;
    assign {eng_waddr, eng_wdata, eng_wstrb, eng_wlast} = w_fifo_out;

endmodule

`default_nettype wire

// File: tb/tb_spi_axi_wr_slave.sv
// ============================================================================
// Module      : tb_spi_axi_wr_slave
// Description : Directed self-checking bench for spi_axi_wr_slave.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_spi_axi_wr_slave;

    localparam int DW = 128;
    localparam int AW = 32;
    localparam int IDW = 6;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [IDW-1:0]  awid = '0;
    logic [AW-1:0]   awaddr = '0;
    logic [7:0]      awlen = '0;
    logic [2:0]      awsize = '0;
    logic [1:0]      awburst = '0;
    logic            awlock = 1'b0;
    logic [2:0]      awcache = '0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [DW-1:0]   wdata = '0;
    logic [DW/8-1:0] wstrb = '0;
    logic            wlast = 1'b0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [IDW-1:0]  bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b0;
    logic            eng_wvalid;
    logic            eng_wready = 1'b1;
    logic [AW-1:0]   eng_waddr;
    logic [DW-1:0]   eng_wdata;
    logic [DW/8-1:0] eng_wstrb;
    logic            eng_wlast;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] q_addr [$];
    logic [DW-1:0] q_data [$];
    logic          q_last [$];

    spi_axi_wr_slave #(.DW(DW), .AW(AW), .IDW(IDW), .FIFO_DEPTH(16)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .spi_if_awid    (awid),
        .spi_if_awaddr  (awaddr),
        .spi_if_awlen   (awlen),
        .spi_if_awsize  (awsize),
        .spi_if_awburst (awburst),
        .spi_if_awlock  (awlock),
        .spi_if_awcache (awcache),
        .spi_if_awvalid (awvalid),
        .spi_if_awready (awready),
        .spi_if_wdata   (wdata),
        .spi_if_wstrb   (wstrb),
        .spi_if_wlast   (wlast),
        .spi_if_wvalid  (wvalid),
        .spi_if_wready  (wready),
        .spi_if_bid     (bid),
        .spi_if_bresp   (bresp),
        .spi_if_bvalid  (bvalid),
        .spi_if_bready  (bready),
        .eng_wvalid     (eng_wvalid),
        .eng_wready     (eng_wready),
        .eng_waddr      (eng_waddr),
        .eng_wdata      (eng_wdata),
        .eng_wstrb      (eng_wstrb),
        .eng_wlast      (eng_wlast)
    );

    always #5 aclk = ~aclk;

    // Engine-side beats are recorded mid-cycle, ahead of the popping edge
    always @(negedge aclk) begin
        if (aresetn && eng_wvalid && eng_wready) begin
            q_addr.push_back(eng_waddr);
            q_data.push_back(eng_wdata);
            q_last.push_back(eng_wlast);
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        q_addr.delete();
        q_data.delete();
        q_last.delete();
    endtask

    function automatic logic [DW-1:0] beat_data(input logic [7:0] tag, input int i);
        return {56'd0, tag, 64'(i)};
    endfunction

    task automatic do_aw(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int cnt;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        awvalid = 1'b1;
        cnt = 0;
        while (!awready && cnt < 50) begin
            tick();
            cnt++;
        end
        chk("aw_handshake", awready, 1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic do_w(input int first, input int n, input int last_idx, input logic [7:0] tag);
        int cnt;
        for (int i = first; i < first + n; i++) begin
            wvalid = 1'b1;
            wdata  = beat_data(tag, i);
            wstrb  = '1;
            wlast  = (i == last_idx);
            cnt = 0;
            while (!wready && cnt < 100) begin
                tick();
                cnt++;
            end
            if (!wready) begin
                chk("w_handshake", wready, 1);
            end
            tick();
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic wait_b(input logic [IDW-1:0] exp_id, input logic [1:0] exp_resp);
        int cnt;
        bready = 1'b1;
        cnt = 0;
        while (!bvalid && cnt < 50) begin
            tick();
            cnt++;
        end
        chk("bvalid", bvalid, 1);
        chk("bid", bid, exp_id);
        chk("bresp", bresp, exp_resp);
        tick();
        bready = 1'b0;
        chk("bvalid_drop", bvalid, 0);
        chk("awready_after_b", awready, 1);
    endtask

    task automatic drain();
        repeat (30) tick();
    endtask

    function automatic logic [AW-1:0] qa(input int i);
        return (i < q_addr.size()) ? q_addr[i] : 'x;
    endfunction
    function automatic logic [DW-1:0] qd(input int i);
        return (i < q_data.size()) ? q_data[i] : 'x;
    endfunction
    function automatic logic ql(input int i);
        return (i < q_last.size()) ? q_last[i] : 1'bx;
    endfunction

    initial begin
        logic [AW-1:0] wrap_exp [4];
        wrap_exp = '{32'h1030, 32'h1000, 32'h1010, 32'h1020};

        // Reset state
        repeat (3) tick();
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_bid", bid, 0);
        chk("rst_eng_wvalid", eng_wvalid, 0);
        chk("rst_eng_waddr", eng_waddr, 0);
        chk("rst_eng_wdata", eng_wdata, 0);
        aresetn = 1'b1;
        chk("rel_awready", awready, 0);
        tick();
        chk("first_awready", awready, 1);

        // INCR len=3 size=4
        clear_q();
        do_aw(6'h15, 32'h1000, 8'd3, 3'd4, 2'b01);
        chk("incr_wready", wready, 1);
        do_w(0, 4, 3, 8'hA1);
        chk("incr_bvalid_lat", bvalid, 1);
        wait_b(6'h15, 2'b00);
        drain();
        chk("incr_nbeats", q_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("incr_addr", qa(i), 32'h1000 + 32'(i) * 32'h10);
            chk("incr_data", qd(i), beat_data(8'hA1, i));
            chk("incr_last", ql(i), (i == 3));
        end

        // WRAP len=3 size=4
        clear_q();
        do_aw(6'h02, 32'h1030, 8'd3, 3'd4, 2'b10);
        do_w(0, 4, 3, 8'hB2);
        wait_b(6'h02, 2'b00);
        drain();
        chk("wrap_nbeats", q_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_addr", qa(i), wrap_exp[i]);
        end

        // WRAP len=2 is illegal
        clear_q();
        do_aw(6'h03, 32'h1000, 8'd2, 3'd4, 2'b10);
        do_w(0, 3, 2, 8'hB3);
        wait_b(6'h03, 2'b10);
        drain();
        chk("wrap_err_nbeats", q_addr.size(), 0);

        // FIXED len=7 size=2
        clear_q();
        do_aw(6'h04, 32'h2004, 8'd7, 3'd2, 2'b00);
        do_w(0, 8, 7, 8'hC4);
        wait_b(6'h04, 2'b00);
        drain();
        chk("fixed_nbeats", q_addr.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("fixed_addr", qa(i), 32'h2004);
        end
        chk("fixed_last", ql(7), 1);

        // awsize beyond the bus width
        clear_q();
        do_aw(6'h05, 32'h3000, 8'd7, 3'd5, 2'b01);
        do_w(0, 8, 7, 8'hC5);
        wait_b(6'h05, 2'b10);
        drain();
        chk("size_err_nbeats", q_addr.size(), 0);

        // Backpressure: 20 beats into a 16-deep FIFO
        clear_q();
        eng_wready = 1'b0;
        do_aw(6'h06, 32'h4000, 8'd19, 3'd4, 2'b01);
        do_w(0, 16, 19, 8'hD6);
        chk("bp_wready_full", wready, 0);
        chk("bp_eng_wvalid", eng_wvalid, 1);
        repeat (3) tick();
        chk("bp_wready_held", wready, 0);
        chk("bp_no_b", bvalid, 0);
        eng_wready = 1'b1;
        do_w(16, 4, 19, 8'hD6);
        chk("bp_bvalid_lat", bvalid, 1);
        wait_b(6'h06, 2'b00);
        drain();
        chk("bp_nbeats", q_addr.size(), 20);
        for (int i = 0; i < 20; i++) begin
            chk("bp_addr", qa(i), 32'h4000 + 32'(i) * 32'h10);
            chk("bp_data", qd(i), beat_data(8'hD6, i));
        end
        chk("bp_last", ql(19), 1);

        // Early wlast: beats still pushed, sticky SLVERR, B held under stall
        clear_q();
        do_aw(6'h27, 32'h6000, 8'd3, 3'd4, 2'b01);
        do_w(0, 4, 2, 8'hE7);
        for (int k = 0; k < 5; k++) begin
            chk("stall_bvalid", bvalid, 1);
            chk("stall_bid", bid, 6'h27);
            chk("stall_bresp", bresp, 2'b10);
            tick();
        end
        wait_b(6'h27, 2'b10);
        drain();
        chk("wlast_nbeats", q_addr.size(), 4);
        chk("wlast_addr3", qa(3), 32'h6030);

        // Reset mid-burst
        clear_q();
        eng_wready = 1'b0;
        do_aw(6'h08, 32'h7000, 8'd7, 3'd4, 2'b01);
        do_w(0, 2, 99, 8'hF8);
        chk("mid_eng_wvalid", eng_wvalid, 1);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_eng_wvalid", eng_wvalid, 0);
        chk("mid_rst_bvalid", bvalid, 0);
        chk("mid_rst_wready", wready, 0);
        tick();
        aresetn = 1'b1;
        tick();
        chk("mid_rel_awready", awready, 1);
        chk("mid_rel_bvalid", bvalid, 0);
        chk("mid_rel_eng_wvalid", eng_wvalid, 0);
        eng_wready = 1'b1;
        clear_q();
        do_aw(6'h2A, 32'h5000, 8'd0, 3'd4, 2'b01);
        do_w(0, 1, 0, 8'h9A);
        chk("post_bvalid_lat", bvalid, 1);
        wait_b(6'h2A, 2'b00);
        drain();
        chk("post_nbeats", q_addr.size(), 1);
        chk("post_addr", qa(0), 32'h5000);
        chk("post_last", ql(0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_axi_wr_slave.md
# spi_axi_wr_slave

AXI4 write-channel slave for the QSPI controller. Accepts AW/W bursts from the interconnect, generates per-beat byte addresses for FIXED, INCR and WRAP bursts, and buffers beats in a parametrised FIFO toward the SPI write engine. Returns the B response once the burst is posted. Sits between the system AXI fabric and the QSPI program/write datapath.

## Interface
Parameters:
- DW, 128, AXI data width in bits (power of two, ≥32)
- AW, 32, address width
- IDW, 6, AXI ID width
- FIFO_DEPTH, 16, beat FIFO depth (power of two, ≥2)

Ports:
- aclk  in  1  single clock
- aresetn  in  1  asynchronous, active-low reset
- spi_if_awid / awaddr / awlen / awsize / awburst / awlock / awcache  in  IDW/AW/8/3/2/1/3  AXI write address
- spi_if_awvalid  in  1 ; spi_if_awready  out  1
- spi_if_wdata / wstrb / wlast  in  DW/DW/8/1  AXI write data
- spi_if_wvalid  in  1 ; spi_if_wready  out  1
- spi_if_bid  out  IDW ; spi_if_bresp  out  2 ; spi_if_bvalid  out  1 ; spi_if_bready  in  1
- eng_wvalid  out  1  beat available to SPI engine
- eng_wready  in  1  engine accepts beat
- eng_waddr / eng_wdata / eng_wstrb / eng_wlast  out  AW/DW/DW/8/1  beat address, data, strobes, last-of-burst

## Operation
- One burst in flight. FSM: IDLE → DATA → RESP → IDLE.
- IDLE: awready=1. On AW handshake, latch id, addr, len, size, burst; evaluate error; go DATA.
- Error (bresp=SLVERR) if: awsize > log2(DW/8); awburst=2'b11; WRAP with awlen ∉ {1,3,7,15}; WRAP with addr not aligned to 2^awsize. awlock=1 is treated as a normal write, response OKAY (no exclusive support). awcache ignored.
- DATA: wready = !fifo_full (error burst: wready=1, beats discarded, nothing pushed). Each W handshake pushes {addr, wdata, wstrb, beat==awlen}, then advances beat counter and address.
- Address: FIXED holds; INCR adds 2^awsize; WRAP adds 2^awsize within a (awlen+1)·2^awsize boundary, low bits wrapping, upper bits held. Counter is 8 bits; beat count is awlen+1 (1..256).
- Burst ends at beat awlen regardless of wlast. wlast≠(beat==awlen) on any beat sets sticky SLVERR; already-pushed beats are not recalled.
- RESP: bvalid=1, bid=latched id, bresp per error flag; hold stable until bready.
- FIFO read side: eng_wvalid = !fifo_empty; pop on eng_wvalid&&eng_wready. Outputs stable while eng_wvalid=1 and eng_wready=0.

## Timing
- Reset values: awready=0 during reset, 1 on first edge after release; wready=0, bvalid=0, bresp=0, bid=0, eng_wvalid=0, eng_w* =0; FIFO empty; state IDLE.
- AW handshake at cycle T → wready may assert at T+1.
- W push at cycle P → eng_wvalid at P+1 (registered FIFO, 1-cycle latency).
- Last W handshake at L → bvalid at L+1. B handshake at R → awready at R+1.
- Full FIFO: wready drops same cycle count reaches FIFO_DEPTH; simultaneous push and pop when full is not allowed (wready already low); simultaneous push/pop when non-full keeps count.
- B issued when last beat enters FIFO (posted); does not wait for engine drain.
- Reset mid-burst: FIFO flushed, FSM to IDLE, no B issued for the aborted burst.

## Structure
- Package spi_axi_pkg: burst encodings (FIXED/INCR/WRAP), resp codes (OKAY/SLVERR), FSM state encoding, wrap-mask helper function.
- One sub-module: spi_sync_fifo (parametrised width/depth, registered output, full/empty/count).
- Address generator and error check live in the top module.

## Test plan
- INCR awaddr=0x1000 len=3 size=4 → eng_waddr 0x1000,0x1010,0x1020,0x1030, eng_wlast on 4th, bresp=OKAY, bid echoes awid=0x15.
- WRAP awaddr=0x1030 len=3 size=4 → eng_waddr 0x1030,0x1000,0x1010,0x1020; WRAP len=2 → SLVERR, no eng beats.
- FIXED awaddr=0x2004 len=7 size=2 → eight beats all 0x2004; awsize=5 with DW=128 → 8 beats accepted, discarded, SLVERR.
- Backpressure: eng_wready=0, INCR len=19 → wready low after 16 beats; release eng_wready → remaining 4 beats flow, bvalid after 20th push, data order preserved.
- wlast asserted on beat 2 of len=3 burst → 4 beats pushed, bresp=SLVERR; bready held low 5 cycles → bvalid/bid/bresp stable.
- aresetn low mid-DATA (beat 2 of 8) → eng_wvalid=0, no bvalid, next AW accepted normally after release.
